led_pulser: RTL and testbench

LED_PULSER -- requirements
Module: led_pulser

---
 rtl/led_pulser.sv | 115 +++++++++++
 tb/tb_led_pulser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pulser.sv
// Triggered LED pulse generator: each request yields a fixed-length active pulse followed by a
// mandatory inactive gap; requests arriving while busy are queued in a saturating counter.
module led_pulser #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PEND_W     = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              trig_i,
  input  logic [CNT_W-1:0]  on_len_i,
  input  logic [CNT_W-1:0]  off_len_i,
  input  logic              ovf_clr_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               on_q, on_d;

  logic tmr_zero;
  logic start;
  logic pend_full;

  assign tmr_zero  = (timer_q == '0);
  assign pend_full = &pend_q;
  // A new pulse may begin from idle or in the very last gap cycle.
  assign start     = ((state_q == StIdle) || ((state_q == StGap) && tmr_zero)) &&
                     (trig_i || (pend_q != '0));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StOn;
          timer_d = on_len_i;
        end
      end
      StOn: begin
        if (tmr_zero) begin
          state_d = StGap;
          timer_d = off_len_i;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      StGap: begin
        if (tmr_zero) begin
          if (start) begin
            state_d = StOn;
            timer_d = on_len_i;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
    on_d = (state_d == StOn);
  end

  // A trig taken by start in the same cycle never touches the queue.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (trig_i && !start) begin
      if (pend_full) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!trig_i && start) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      on_q    <= on_d;
    end
  end

  assign led_o  = ACTIVE_LOW ? ~on_q : on_q;
  assign busy_o = (state_q != StIdle);
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_led_pulser.sv
// Self-checking bench for led_pulser: per-cycle expected {led,busy,pend,ovf} pushed to a
// scoreboard queue as stimulus is driven, popped and compared after each clock edge.
module tb_led_pulser;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PEND_W = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              trig_i;
  logic [CNT_W-1:0]  on_len_i;
  logic [CNT_W-1:0]  off_len_i;
  logic              ovf_clr_i;
  logic              led_o;
  logic              busy_o;
  logic [PEND_W-1:0] pend_o;
  logic              ovf_o;

  int checks   = 0;
  int failures = 0;

  logic [4:0] sb_q[$];
  logic [4:0] obs;
  logic [4:0] e;

  assign obs = {led_o, busy_o, pend_o, ovf_o};

  led_pulser #(
    .CNT_W     (CNT_W),
    .PEND_W    (PEND_W),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .trig_i   (trig_i),
    .on_len_i (on_len_i),
    .off_len_i(off_len_i),
    .ovf_clr_i(ovf_clr_i),
    .led_o    (led_o),
    .busy_o   (busy_o),
    .pend_o   (pend_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [4:0] mk(input logic l, input logic b, input logic [1:0] p,
                                    input logic o);
    return {l, b, p, o};
  endfunction

  task automatic drive_cycle(input logic t, input logic c);
    trig_i    = t;
    ovf_clr_i = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive_cycle(1'b0, 1'b0);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0));
      drive_cycle(1'b1, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset k=%0d got=%b exp=%b", k, obs, e);
      end
    end
    rst_ni = 1'b1;
    sb_q.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0));
    drive_cycle(1'b0, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_single();
    do_reset();
    on_len_i  = 16'd3;
    off_len_i = 16'd1;
    for (int k = 0; k < 9; k++) begin
      sb_q.push_back(mk(!(k < 4), (k < 6), 2'd0, 1'b0));
      drive_cycle(k == 0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL single k=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] led_x  = 7'b1101010;  // index k: bit k
    logic [6:0] busy_x = 7'b0111111;
    logic [1:0] pend_x [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    do_reset();
    on_len_i  = 16'd0;
    off_len_i = 16'd0;
    for (int k = 0; k < 7; k++) begin
      sb_q.push_back(mk(led_x[k], busy_x[k], pend_x[k], 1'b0));
      drive_cycle(k < 3, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] p;
    do_reset();
    on_len_i  = 16'd9;
    off_len_i = 16'd0;
    for (int k = 0; k < 48; k++) begin
      p = (k < 4) ? 2'(k) : (k < 11) ? 2'd3 : (k < 22) ? 2'd2 : (k < 33) ? 2'd1 : 2'd0;
      sb_q.push_back(mk(!((k % 11) <= 9 && k <= 42), (k <= 43), p, (k >= 4 && k < 46)));
      // Clear coincides with the overflow at k=4 (set must win), then clears alone at k=46.
      drive_cycle(k < 5, (k == 4) || (k == 46));
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL overflow k=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask

  task automatic test_len_change();
    logic [1:0] p;
    do_reset();
    on_len_i  = 16'd5;
    off_len_i = 16'd0;
    for (int k = 0; k < 12; k++) begin
      p = (k >= 1 && k <= 6) ? 2'd1 : 2'd0;
      sb_q.push_back(mk(!(k <= 5 || k == 7 || k == 8), (k <= 9), p, 1'b0));
      drive_cycle(k < 2, 1'b0);
      if (k == 1) on_len_i = 16'd1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL len_change k=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    on_len_i  = 16'd9;
    off_len_i = 16'd0;
    for (int k = 0; k < 15; k++) begin
      sb_q.push_back((k < 3) ? mk(1'b0, 1'b1, 2'(k), 1'b0) : mk(1'b1, 1'b0, 2'd0, 1'b0));
      rst_ni = (k != 3);
      drive_cycle(k < 4, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid k=%0d got=%b exp=%b", k, obs, e);
      end
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_gap_trig();
    do_reset();
    on_len_i  = 16'd2;
    off_len_i = 16'd2;
    for (int k = 0; k < 14; k++) begin
      sb_q.push_back(mk(!(k <= 2 || (k >= 6 && k <= 8)), (k <= 11), 2'd0, 1'b0));
      drive_cycle((k == 0) || (k == 6), 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL gap_trig k=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    trig_i    = 1'b0;
    ovf_clr_i = 1'b0;
    on_len_i  = '0;
    off_len_i = '0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_len_change();
    test_reset_mid();
    test_gap_trig();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
